// File: rtl/vanilla_core_flat.sv
// vanilla_core_flat
// Single-issue core: 16-bit instructions, 32-bit datapath. The core boots over
// a packet port that loads instruction memory, the register file, the barrier
// mask and the start PC. After that it runs one instruction per cycle and
// stalls on external data-memory accesses, which use a valid/yumi handshake.
//
// Ports
//   clk                clock; all state changes on posedge
//   reset              synchronous, active-low
//   net_packet_flat_i  {ID[59:50], op[49:47], rsvd[46:42], data[41:10], addr[9:0]}
//   net_packet_flat_o  same layout, tied to zero
//   from_mem_flat_i    {valid[33], yumi[32], read_data[31:0]}
//   to_mem_flat_o      {valid[35], wen[34], byte_not_word[33], yumi[32], write_data[31:0]}
//   data_mem_addr      byte address of the outstanding request
//   barrier_o          barrier output, loaded from mask_r by the BAR instruction
//   exception_o        sticky illegal-opcode flag, cleared by a PC packet
//   debug_flat_o       {state[31:30], 4'b0, pc[25:16], instr[15:0]}
module vanilla_core_flat #(
  parameter int IMEM_WORDS_P = 1024,
  parameter int RF_REGS_P    = 64,
  parameter int MASK_LEN_P   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [59:0]           net_packet_flat_i,
  output logic [59:0]           net_packet_flat_o,
  input  logic [33:0]           from_mem_flat_i,
  output logic [35:0]           to_mem_flat_o,
  output logic [31:0]           data_mem_addr,
  output logic [MASK_LEN_P-1:0] barrier_o,
  output logic                  exception_o,
  output logic [31:0]           debug_flat_o
);

  localparam int PC_W  = 10;
  localparam int RF_AW = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_MEM  = 2'd2,
    S_HALT = 2'd3
  } state_e;

  // Outstanding data-memory request. The fields stay constant while valid is set.
  typedef struct packed {
    logic        valid;
    logic        wen;
    logic        byte_nw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } mem_req_t;

  localparam logic [4:0] OP_ADDU  = 5'h00, OP_SUBU  = 5'h01, OP_SLLV  = 5'h02,
                         OP_SRAV  = 5'h03, OP_SRLV  = 5'h04, OP_AND   = 5'h05,
                         OP_OR    = 5'h06, OP_NOR   = 5'h07, OP_SLT   = 5'h08,
                         OP_SLTU  = 5'h09, OP_MOV   = 5'h0A, OP_LI    = 5'h0B,
                         OP_LW    = 5'h0C, OP_LBU   = 5'h0D, OP_SW    = 5'h0E,
                         OP_SB    = 5'h0F, OP_BEQZ  = 5'h10, OP_BNEQZ = 5'h11,
                         OP_BGTZ  = 5'h12, OP_BLTZ  = 5'h13, OP_JALR  = 5'h14,
                         OP_BAR   = 5'h15, OP_NOP   = 5'h16, OP_HALT  = 5'h17;

  localparam logic [2:0] NET_INSTR = 3'd1, NET_REG = 3'd2, NET_PC = 3'd3, NET_BAR = 3'd4;

  // ---------------- storage ----------------
  logic [15:0]           imem [IMEM_WORDS_P];
  logic [31:0]           rf   [RF_REGS_P];
  state_e                state_r, state_nxt;
  logic [PC_W-1:0]       pc_r, pc_nxt, pc_inc;
  logic [MASK_LEN_P-1:0] mask_r;
  mem_req_t              mem_r;

  // ---------------- packet decode ----------------
  logic [9:0]  pkt_id;
  logic [2:0]  pkt_op;
  logic [31:0] pkt_data;
  logic [9:0]  pkt_addr;
  logic        pkt_ok, pkt_instr, pkt_reg, pkt_pc, pkt_bar;

  assign pkt_id    = net_packet_flat_i[59:50];
  assign pkt_op    = net_packet_flat_i[49:47];
  assign pkt_data  = net_packet_flat_i[41:10];
  assign pkt_addr  = net_packet_flat_i[9:0];
  assign pkt_ok    = (pkt_id == 10'd1);
  assign pkt_instr = pkt_ok && (pkt_op == NET_INSTR);
  assign pkt_reg   = pkt_ok && (pkt_op == NET_REG);
  assign pkt_pc    = pkt_ok && (pkt_op == NET_PC);
  assign pkt_bar   = pkt_ok && (pkt_op == NET_BAR);

  // ---------------- memory response ----------------
  logic        mem_vld_in;
  logic [31:0] rd_data;
  assign mem_vld_in = from_mem_flat_i[33];
  assign rd_data    = from_mem_flat_i[31:0];

  // ---------------- fetch / decode ----------------
  logic [15:0]     instr;
  logic [4:0]      opcode, rd_f;
  logic [5:0]      rs_f;
  logic [31:0]     rd_val, rs_val;
  logic [PC_W-1:0] br_off;

  assign instr  = imem[pc_r];
  assign opcode = instr[15:11];
  assign rd_f   = instr[10:6];
  assign rs_f   = instr[5:0];
  assign rd_val = rf[{1'b0, rd_f}];
  assign rs_val = rf[rs_f];
  assign pc_inc = pc_r + 1'b1;
  assign br_off = {{(PC_W-6){rs_f[5]}}, rs_f};

  // ---------------- execute (FSM output logic) ----------------
  logic             wb_en;
  logic [RF_AW-1:0] wb_idx;
  logic [31:0]      wb_data;
  logic             mem_start, mem_wen, mem_byte;
  logic             bar_fire, exc_set, halt_req, yumi, br_taken;

  // A PC packet overrides whatever the core would have done this cycle,
  // including completing an outstanding access.
  always_comb begin
    wb_en     = 1'b0;
    wb_idx    = {1'b0, rd_f};
    wb_data   = '0;
    pc_nxt    = pc_r;
    mem_start = 1'b0;
    mem_wen   = 1'b0;
    mem_byte  = 1'b0;
    bar_fire  = 1'b0;
    exc_set   = 1'b0;
    halt_req  = 1'b0;
    yumi      = 1'b0;
    br_taken  = 1'b0;
    if (!pkt_pc) begin
      case (state_r)
        S_RUN: begin
          pc_nxt = pc_inc;
          case (opcode)
            OP_ADDU: begin wb_en = 1'b1; wb_data = rd_val + rs_val; end
            OP_SUBU: begin wb_en = 1'b1; wb_data = rd_val - rs_val; end
            OP_SLLV: begin wb_en = 1'b1; wb_data = rd_val << rs_val[4:0]; end
            OP_SRAV: begin wb_en = 1'b1; wb_data = $unsigned($signed(rd_val) >>> rs_val[4:0]); end
            OP_SRLV: begin wb_en = 1'b1; wb_data = rd_val >> rs_val[4:0]; end
            OP_AND:  begin wb_en = 1'b1; wb_data = rd_val & rs_val; end
            OP_OR:   begin wb_en = 1'b1; wb_data = rd_val | rs_val; end
            OP_NOR:  begin wb_en = 1'b1; wb_data = ~(rd_val | rs_val); end
            OP_SLT:  begin wb_en = 1'b1; wb_data = {31'b0, $signed(rd_val) < $signed(rs_val)}; end
            OP_SLTU: begin wb_en = 1'b1; wb_data = {31'b0, rd_val < rs_val}; end
            OP_MOV:  begin wb_en = 1'b1; wb_data = rs_val; end
            OP_LI:   begin wb_en = 1'b1; wb_data = {26'b0, rs_f}; end
            OP_LW, OP_LBU, OP_SW, OP_SB: begin
              // pc holds on the memory instruction until the response arrives
              mem_start = 1'b1;
              pc_nxt    = pc_r;
              mem_wen   = (opcode == OP_SW) || (opcode == OP_SB);
              mem_byte  = (opcode == OP_LBU) || (opcode == OP_SB);
            end
            OP_BEQZ:  br_taken = (rd_val == 32'd0);
            OP_BNEQZ: br_taken = (rd_val != 32'd0);
            OP_BGTZ:  br_taken = ($signed(rd_val) > 0);
            OP_BLTZ:  br_taken = rd_val[31];
            OP_JALR: begin
              wb_en   = 1'b1;
              wb_data = {{(32-PC_W){1'b0}}, pc_inc};
              pc_nxt  = rs_val[PC_W-1:0];
            end
            OP_BAR:  bar_fire = 1'b1;
            OP_NOP:  ;
            OP_HALT: begin halt_req = 1'b1; pc_nxt = pc_r; end
            default: begin exc_set = 1'b1; pc_nxt = pc_r; end
          endcase
          if (br_taken) pc_nxt = pc_r + br_off;
        end
        S_MEM: begin
          if (mem_vld_in) begin
            yumi   = 1'b1;
            pc_nxt = pc_inc;
            if (!mem_r.wen) begin
              wb_en   = 1'b1;
              wb_idx  = {1'b0, mem_r.rd};
              wb_data = mem_r.byte_nw ? {24'b0, rd_data[7:0]} : rd_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    state_nxt = state_r;
    if (pkt_pc) state_nxt = S_RUN;
    else begin
      case (state_r)
        S_RUN: begin
          if (exc_set)        state_nxt = S_HALT;
          else if (halt_req)  state_nxt = S_IDLE;
          else if (mem_start) state_nxt = S_MEM;
        end
        S_MEM:   if (mem_vld_in) state_nxt = S_RUN;
        default: ;
      endcase
    end
  end

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (!reset) state_r <= S_IDLE;
    else        state_r <= state_nxt;
  end

  // ---------------- pc / flags / barrier ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_r        <= '0;
      exception_o <= 1'b0;
      mask_r      <= '0;
      barrier_o   <= '0;
    end else begin
      pc_r <= pkt_pc ? pkt_addr[PC_W-1:0] : pc_nxt;
      if (pkt_pc)       exception_o <= 1'b0;
      else if (exc_set) exception_o <= 1'b1;
      if (pkt_bar)  mask_r    <= pkt_data[MASK_LEN_P-1:0];
      if (bar_fire) barrier_o <= mask_r;
    end
  end

  // ---------------- memory request register ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_r <= '0;
    end else if (pkt_pc) begin
      mem_r.valid <= 1'b0;
    end else if (mem_start) begin
      mem_r.valid   <= 1'b1;
      mem_r.wen     <= mem_wen;
      mem_r.byte_nw <= mem_byte;
      mem_r.addr    <= rs_val;
      mem_r.wdata   <= (opcode == OP_SB) ? {24'b0, rd_val[7:0]} : rd_val;
      mem_r.rd      <= rd_f;
    end else if (yumi) begin
      mem_r.valid <= 1'b0;
    end
  end

  // ---------------- imem / register file (not reset) ----------------
  always_ff @(posedge clk) begin
    if (reset && pkt_instr) imem[pkt_addr] <= pkt_data[15:0];
  end

  // The packet write comes last so it wins over a core write to the same reg.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (wb_en)   rf[wb_idx]        <= wb_data;
      if (pkt_reg) rf[pkt_addr[5:0]] <= pkt_data;
    end
  end

  // ---------------- outputs ----------------
  assign net_packet_flat_o = '0;
  assign to_mem_flat_o     = {mem_r.valid, mem_r.wen, mem_r.byte_nw, yumi, mem_r.wdata};
  assign data_mem_addr     = mem_r.addr;
  assign debug_flat_o      = {state_r, 4'b0, pc_r, instr};

  logic unused_bits;
  assign unused_bits = ^{net_packet_flat_i[46:42], from_mem_flat_i[32]};

endmodule

// File: tb/tb_vanilla_core_flat.sv
// Directed bench for vanilla_core_flat. It preloads registers and a program
// over the packet port. Every memory request it expects is queued on a
// scoreboard while the stimulus is set up. When the core raises a request,
// the bench pops the next entry, compares the request against it and answers
// with the entry's read data.
module tb_vanilla_core_flat;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [59:0] net_i, net_o;
  logic [33:0] from_mem;
  logic [35:0] to_mem;
  logic [31:0] dm_addr, dbg;
  logic [2:0]  bar;
  logic        exc;

  int total = 0;
  int passed = 0;

  typedef struct {
    string       tag;
    logic        wen;
    logic        bnw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  logic [15:0] prog [32];

  always #5 clk = ~clk;

  vanilla_core_flat dut (
    .clk(clk), .reset(reset),
    .net_packet_flat_i(net_i), .net_packet_flat_o(net_o),
    .from_mem_flat_i(from_mem), .to_mem_flat_o(to_mem),
    .data_mem_addr(dm_addr), .barrier_o(bar),
    .exception_o(exc), .debug_flat_o(dbg)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: sim time limit reached, total=%0d passed=%0d", total, passed);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] enc(input logic [4:0] op, input logic [4:0] rd, input logic [5:0] rs);
    return {op, rd, rs};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [2:0] op, input logic [9:0] addr, input logic [31:0] data);
    net_i = {10'd1, op, 5'd0, data, addr};
    tick();
    net_i = '0;
  endtask

  task automatic push(input string tag, input logic wen, input logic bnw,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata);
    exp_t e;
    e.tag = tag; e.wen = wen; e.bnw = bnw; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    sb.push_back(e);
  endtask

  // Wait for the next request and check it against the scoreboard head.
  // Optionally hold off the response for 'stall' cycles and confirm the core waits.
  task automatic serve(input int stall, input logic [9:0] stall_pc);
    exp_t e;
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (to_mem[35]) begin seen = 1'b1; break; end
      tick();
    end
    chk("req_seen", seen, 1'b1);
    if (!seen || sb.size() == 0) return;
    e = sb.pop_front();
    chk({e.tag, ".wen"},   to_mem[34],   e.wen);
    chk({e.tag, ".byte"},  to_mem[33],   e.bnw);
    chk({e.tag, ".addr"},  dm_addr,      e.addr);
    chk({e.tag, ".wdata"}, to_mem[31:0], e.wdata);
    if (stall > 0) begin
      repeat (stall) tick();
      chk({e.tag, ".stall_pc"},    dbg[25:16], stall_pc);
      chk({e.tag, ".stall_state"}, dbg[31:30], 2'd2);
      chk({e.tag, ".stall_valid"}, to_mem[35], 1'b1);
      chk({e.tag, ".stall_addr"},  dm_addr,    e.addr);
    end
    from_mem = {1'b1, 1'b0, e.rdata};
    #1;
    chk({e.tag, ".yumi"}, to_mem[32], 1'b1);
    tick();
    from_mem = '0;
    chk({e.tag, ".valid_drop"}, to_mem[35], 1'b0);
  endtask

  task automatic wait_pc(input logic [9:0] target);
    logic hit;
    hit = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (dbg[25:16] == target) begin hit = 1'b1; break; end
      tick();
    end
    chk("wait_pc", hit, 1'b1);
  endtask

  initial begin
    logic seen;
    net_i = '0;
    from_mem = '0;
    reset = 1'b0;
    repeat (3) tick();
    chk("rst.state",  dbg[31:30], 2'd0);
    chk("rst.pc",     dbg[25:16], 10'd0);
    chk("rst.to_mem", to_mem,     36'd0);
    chk("rst.addr",   dm_addr,    32'd0);
    chk("rst.exc",    exc,        1'b0);
    chk("rst.bar",    bar,        3'd0);
    chk("rst.net_o",  net_o,      60'd0);
    reset = 1'b1;

    // register preload
    send(3'd2, 10'd0,  32'd0);
    send(3'd2, 10'd1,  32'd5);
    send(3'd2, 10'd2,  32'd7);
    send(3'd2, 10'd3,  32'hC0FFEEEE);
    send(3'd2, 10'd4,  32'd0);
    send(3'd2, 10'd5,  32'd0);
    send(3'd2, 10'd6,  32'h1000);
    send(3'd2, 10'd7,  32'hFFFFFFFF);
    send(3'd2, 10'd8,  32'h600DBEEF);
    send(3'd2, 10'd9,  32'hAABBCCDD);
    send(3'd2, 10'd11, 32'd0);
    send(3'd2, 10'd12, 32'd20);
    send(3'd2, 10'd13, 32'd4);
    send(3'd2, 10'd14, 32'h80000000);

    for (int i = 0; i < 32; i++) prog[i] = enc(5'h16, 5'd0, 6'd0);
    prog[0]  = enc(5'h00, 5'd1,  6'd2);    // ADDU r1,r2
    prog[1]  = enc(5'h0E, 5'd1,  6'd3);    // SW r1,[r3]
    prog[2]  = enc(5'h0C, 5'd4,  6'd6);    // LW r4,[r6]
    prog[3]  = enc(5'h0E, 5'd4,  6'd3);    // SW r4,[r3]
    prog[4]  = enc(5'h0D, 5'd4,  6'd6);    // LBU r4,[r6]
    prog[5]  = enc(5'h0E, 5'd4,  6'd3);    // SW r4,[r3]
    prog[7]  = enc(5'h10, 5'd5,  6'd2);    // BEQZ r5,+2 -> 9
    prog[8]  = enc(5'h0B, 5'd5,  6'd1);    // LI r5,1
    prog[10] = enc(5'h10, 5'd5,  6'h3E);   // BEQZ r5,-2
    prog[11] = enc(5'h13, 5'd7,  6'd2);    // BLTZ r7,+2 -> 13
    prog[13] = enc(5'h12, 5'd7,  6'd5);    // BGTZ r7,+5 not taken
    prog[14] = enc(5'h14, 5'd11, 6'd12);   // JALR r11,r12 -> 20
    prog[20] = enc(5'h0E, 5'd11, 6'd3);    // SW r11
    prog[21] = enc(5'h01, 5'd1,  6'd2);    // SUBU r1,r2
    prog[22] = enc(5'h0E, 5'd1,  6'd3);    // SW r1
    prog[23] = enc(5'h03, 5'd14, 6'd13);   // SRAV r14,r13
    prog[24] = enc(5'h0E, 5'd14, 6'd3);    // SW r14
    prog[25] = enc(5'h1F, 5'd0,  6'd0);    // illegal
    prog[26] = enc(5'h0E, 5'd1,  6'd3);    // SW r1 (must never issue)
    for (int i = 0; i < 32; i++) send(3'd1, 10'(i), {16'd0, prog[i]});
    send(3'd4, 10'd0, 32'd0);

    chk("idle.state", dbg[31:30], 2'd0);
    chk("idle.valid", to_mem[35], 1'b0);
    chk("idle.pc",    dbg[25:16], 10'd0);

    push("sw_add",  1'b1, 1'b0, 32'hC0FFEEEE, 32'd5 + 32'd7, 32'd0);
    push("lw",      1'b0, 1'b0, 32'h1000,     32'd0,         32'h12345678);
    push("sw_lw",   1'b1, 1'b0, 32'hC0FFEEEE, 32'h12345678,  32'd0);
    push("lbu",     1'b0, 1'b1, 32'h1000,     32'h12345678,  32'h12345678);
    push("sw_lbu",  1'b1, 1'b0, 32'hC0FFEEEE, 32'h78,        32'd0);
    push("sw_jalr", 1'b1, 1'b0, 32'hC0FFEEEE, 32'd15,        32'd0);
    push("sw_sub",  1'b1, 1'b0, 32'hC0FFEEEE, 32'd12 - 32'd7, 32'd0);
    push("sw_sra",  1'b1, 1'b0, 32'hC0FFEEEE, 32'hF8000000,  32'd0);

    send(3'd3, 10'd0, 32'd0);
    chk("start.state", dbg[31:30], 2'd1);
    chk("start.pc",    dbg[25:16], 10'd0);

    serve(0, 10'd0);
    serve(3, 10'd2);
    serve(0, 10'd0);
    serve(2, 10'd4);
    serve(0, 10'd0);

    wait_pc(10'd10);
    tick(); chk("beqz_taken.pc", dbg[25:16], 10'd8);
    wait_pc(10'd10);
    tick(); chk("beqz_not.pc",   dbg[25:16], 10'd11);
    tick(); chk("bltz_taken.pc", dbg[25:16], 10'd13);
    tick(); chk("bgtz_not.pc",   dbg[25:16], 10'd14);
    tick(); chk("jalr.pc",       dbg[25:16], 10'd20);

    serve(0, 10'd0);
    serve(0, 10'd0);
    serve(0, 10'd0);

    wait_pc(10'd25);
    tick();
    chk("illegal.exc",   exc,        1'b1);
    chk("illegal.state", dbg[31:30], 2'd3);
    seen = 1'b0;
    repeat (6) begin
      if (to_mem[35]) seen = 1'b1;
      tick();
    end
    chk("halt.no_store", seen,       1'b0);
    chk("halt.pc",       dbg[25:16], 10'd25);

    // second program, loaded while halted
    send(3'd1, 10'd0, {16'd0, enc(5'h15, 5'd0, 6'd0)});   // BAR
    send(3'd1, 10'd1, {16'd0, enc(5'h0F, 5'd9, 6'd3)});   // SB r9,[r3]
    send(3'd1, 10'd2, {16'd0, enc(5'h0E, 5'd9, 6'd8)});   // SW r9,[r8]
    send(3'd1, 10'd3, {16'd0, enc(5'h17, 5'd0, 6'd0)});   // HALT
    send(3'd4, 10'd0, 32'h2);
    push("sb",       1'b1, 1'b1, 32'hC0FFEEEE, 32'hDD,       32'd0);
    push("sw_final", 1'b1, 1'b0, 32'h600DBEEF, 32'hAABBCCDD, 32'd0);
    chk("bar.before", bar, 3'd0);

    send(3'd3, 10'd0, 32'd0);
    chk("restart.exc",   exc,        1'b0);
    chk("restart.state", dbg[31:30], 2'd1);
    tick();
    chk("bar.out", bar, 3'b010);

    serve(0, 10'd0);
    serve(0, 10'd0);
    $display("DONE");
    tick();
    chk("final.state", dbg[31:30], 2'd0);
    chk("sb.empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
